// File: rtl/axi_stream_width_pkg.sv
// Shared helpers for the AXI-stream width converters (downsizer now, upsizer later):
// FSM state type, counter sizing, ratio legality and lane selection.
package axi_stream_width_pkg;

    // Widest tdata any converter in this family may carry.
    localparam int MAX_DSIZE = 1024;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    // A 2:1 converter still needs one counter bit.
    function automatic int cnt_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    function automatic bit ratio_ok(input int wide_w, input int narrow_w);
        return (narrow_w > 0) && (wide_w % narrow_w == 0) &&
               (wide_w / narrow_w >= 2) && (wide_w <= MAX_DSIZE);
    endfunction

    // Returns lane idx in the low out_w bits; lane 0 is the LSBs when lsb_first.
    function automatic logic [MAX_DSIZE-1:0] slice_sel(
        input logic [MAX_DSIZE-1:0] data,
        input int unsigned          idx,
        input int unsigned          out_w,
        input int unsigned          ratio,
        input logic                 lsb_first
    );
        int unsigned          lane;
        logic [MAX_DSIZE-1:0] mask;
        lane = lsb_first ? idx : (ratio - 1 - idx);
        mask = ~({MAX_DSIZE{1'b1}} << out_w);
        return (data >> (lane * out_w)) & mask;
    endfunction

endpackage

// File: rtl/axi_stream_downsize_serializer.sv
// Wide-to-narrow AXI-stream serializer: each accepted wide beat leaves as RATIO
// consecutive narrow beats, tlast only on the final slice of a tlast beat.
module axi_stream_downsize_serializer
    import axi_stream_width_pkg::*;
#(
    parameter int IN_DSIZE  = 96,
    parameter int OUT_DSIZE = 32,
    parameter int LSB_FIRST = 1
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic                                    aclken,
    input  logic [IN_DSIZE-1:0]                     s_axis_tdata,
    input  logic                                    s_axis_tlast,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    output logic [OUT_DSIZE-1:0]                    m_axis_tdata,
    output logic                                    m_axis_tlast,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic [$clog2(IN_DSIZE/OUT_DSIZE)-1:0]   slice_idx
);

    localparam int RATIO = IN_DSIZE / OUT_DSIZE;
    localparam int CNT_W = cnt_width(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if (!ratio_ok(IN_DSIZE, OUT_DSIZE)) begin : g_bad_ratio
            $error("axi_stream_downsize_serializer: IN_DSIZE must be an integer multiple >= 2 of OUT_DSIZE");
        end
    endgenerate

    ser_state_t           state;
    ser_state_t           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IN_DSIZE-1:0]  hold_data;
    logic                 hold_last;
    logic                 load;
    logic                 loaded;
    logic                 last_slice;
    logic                 in_fire;
    logic                 out_fire;

    // Valid/ready: a beat moves on a side only in a cycle where valid, ready and
    // aclken are all high; valid never waits for ready, and once m_axis_tvalid
    // rises, m_axis_tdata/m_axis_tlast hold until that beat is taken.
    assign loaded        = (state == ST_SEND);
    assign last_slice    = (cnt == LAST_CNT);
    assign s_axis_tready = aresetn & (~loaded | (last_slice & m_axis_tready));
    assign in_fire       = s_axis_tvalid & s_axis_tready & aclken;
    assign out_fire      = m_axis_tvalid & m_axis_tready & aclken;
    assign slice_idx     = cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (aclken) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Final slice going out while a new wide beat arrives reloads without a bubble.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_fire) begin
                    state_nxt = ST_SEND;
                    cnt_nxt   = '0;
                    load      = 1'b1;
                end
            end
            ST_SEND: begin
                if (out_fire) begin
                    if (!last_slice) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        cnt_nxt = '0;
                        if (in_fire) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (load) begin
            hold_data <= s_axis_tdata;
            hold_last <= s_axis_tlast;
        end
    end

    always_comb begin
        m_axis_tvalid = loaded;
        m_axis_tlast  = hold_last & last_slice & loaded;
        m_axis_tdata  = OUT_DSIZE'(slice_sel(MAX_DSIZE'(hold_data), 32'(cnt),
                                             OUT_DSIZE, RATIO, LSB_FIRST != 0));
    end

endmodule
